mips_multicycle_ctrl: RTL and testbench
=======================================

Name: mips_multicycle_ctrl

Overview:
- Multi-cycle MIPS control FSM.
- Sequences the shared datapath registers (PC, IR, MDR, A/B, ALUOut) and the single unified memory port.
- Decodes the IR opcode and drives per-state enables and mux selects; waits on a memory ready handshake.
- Sits between the instruction register and the datapath register/mux fabric.

Parameters:
- STATE_W, 4, state register width (12 states used).
- OPC_W, 6, opcode field width.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-low reset
- opcode  input  OPC_W  IR[31:26], valid from DECODE onward
- zero  input  1  ALU zero flag, sampled in BRANCH
- mem_ready  input  1  memory access completes this cycle
- pc_en  output  1  PC load enable
- iord  output  1  memory address select: 0=PC, 1=ALUOut
- mem_read  output  1  memory read request
- mem_write  output  1  memory write request
- ir_write  output  1  IR load enable
- reg_dst  output  1  write register select: 0=rt, 1=rd
- mem_to_reg  output  1  writeback data select: 0=ALUOut, 1=MDR
- reg_write  output  1  register-file write enable
- alu_src_a  output  1  ALU A select: 0=PC, 1=A
- alu_src_b  output  2  ALU B select: 00=B, 01=4, 10=signext, 11=signext<<2
- alu_op  output  2  00=add, 01=sub, 10=funct decode
- pc_source  output  2  00=ALU result, 01=ALUOut, 10=jump target
- illegal_op  output  1  one-cycle pulse on an unsupported opcode
- state  output  STATE_W  current state, for debug

Behaviour:
- State codes: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, BRANCH=8, JUMP=9, ADDIEX=10, ADDIWB=11.
- Reset (reset=0 at posedge): state<=FETCH.
  - While reset=0, all enables and requests are forced to 0: pc_en, ir_write, reg_write, mem_read, mem_write, illegal_op.
  - Selects default to 0 during reset.
  - Reset mid-access abandons the access; no write completes.
- Outputs are decoded from state. pc_en and ir_write are additionally qualified by mem_ready (or zero, for BRANCH). Unlisted outputs in a state are 0.
- FETCH:
  - mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00.
  - ir_write=pc_en=mem_ready.
  - Stay in FETCH while mem_ready=0; go to DECODE when mem_ready=1.
- DECODE:
  - alu_src_a=0, alu_src_b=11, alu_op=00 (branch target precompute).
  - Next state by opcode: 100011 or 101011 -> MEMADR; 000000 -> EXEC; 000100 -> BRANCH; 000010 -> JUMP; 001000 -> ADDIEX.
  - Any other opcode -> FETCH, with illegal_op=1 for this one cycle.
- MEMADR: alu_src_a=1, alu_src_b=10, alu_op=00. Next state: lw -> MEMRD, sw -> MEMWR.
- MEMRD: mem_read=1, iord=1. Hold until mem_ready=1, then MEMWB.
- MEMWB: reg_write=1, reg_dst=0, mem_to_reg=1. Next state FETCH.
- MEMWR:
  - mem_write=1, iord=1. Hold until mem_ready=1, then FETCH.
  - mem_write stays asserted every waiting cycle; the memory commits once, on the ready cycle.
- EXEC: alu_src_a=1, alu_src_b=00, alu_op=10. Next state ALUWB.
- ALUWB: reg_write=1, reg_dst=1, mem_to_reg=0. Next state FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_source=01, pc_en=zero. Next state FETCH.
- JUMP: pc_source=10, pc_en=1. Next state FETCH.
- ADDIEX: alu_src_a=1, alu_src_b=10, alu_op=00. Next state ADDIWB.
- ADDIWB: reg_write=1, reg_dst=0, mem_to_reg=0. Next state FETCH.
- Unused state codes 12-15: next state FETCH, all enables 0.
- mem_read and mem_write are never both 1.
- Cycle counts with zero wait states: lw=5, sw=4, R-type=4, addi=4, beq=3, j=3.
- Each wait cycle adds 1 cycle to the state that issued the access.

Test Plan:
- Reset held 0 for 3 cycles, then released; mem_ready=1 -> state=0 during reset with all enables 0; first cycle after release shows mem_read=1, ir_write=1, pc_en=1.
- opcode=100011, mem_ready=1 throughout -> states 0,1,2,3,4,0; reg_write=1 with mem_to_reg=1 only in state 4.
- opcode=101011, mem_ready=0 for 3 cycles in MEMWR -> mem_write=1 for 4 cycles, iord=1; return to FETCH on the ready cycle; reg_write never 1.
- opcode=000100 run twice, zero=1 then zero=0 -> pc_en=1 with pc_source=01 in BRANCH the first time; pc_en=0 the second time; 3 cycles each.
- opcode=000000, then 001000, then 000010 -> R-type reg_dst=1 in ALUWB; addi reg_dst=0 in ADDIWB; jump pc_source=10 with pc_en=1.
- opcode=111111 -> illegal_op=1 for exactly one cycle in DECODE; next state FETCH; no register or memory write.
- reset=0 asserted during a MEMRD wait -> state=FETCH next cycle; reg_write stays 0.

Source files
------------

// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle MIPS control FSM: sequences the shared PC/IR/MDR/A/B/ALUOut datapath
// and the single memory port, decoding the IR opcode and stalling on mem_ready.
module mips_multicycle_ctrl #(
  parameter int STATE_W = 4,
  parameter int OPC_W   = 6
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [OPC_W-1:0]   opcode,
  input  logic               zero,
  input  logic               mem_ready,
  output logic               pc_en,
  output logic               iord,
  output logic               mem_read,
  output logic               mem_write,
  output logic               ir_write,
  output logic               reg_dst,
  output logic               mem_to_reg,
  output logic               reg_write,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [1:0]         alu_op,
  output logic [1:0]         pc_source,
  output logic               illegal_op,
  output logic [STATE_W-1:0] state
);

  typedef enum logic [STATE_W-1:0] {
    FETCH  = STATE_W'(0),
    DECODE = STATE_W'(1),
    MEMADR = STATE_W'(2),
    MEMRD  = STATE_W'(3),
    MEMWB  = STATE_W'(4),
    MEMWR  = STATE_W'(5),
    EXEC   = STATE_W'(6),
    ALUWB  = STATE_W'(7),
    BRANCH = STATE_W'(8),
    JUMP   = STATE_W'(9),
    ADDIEX = STATE_W'(10),
    ADDIWB = STATE_W'(11)
  } state_t;

  localparam logic [OPC_W-1:0] OP_RTYPE = OPC_W'(6'b000000);
  localparam logic [OPC_W-1:0] OP_LW    = OPC_W'(6'b100011);
  localparam logic [OPC_W-1:0] OP_SW    = OPC_W'(6'b101011);
  localparam logic [OPC_W-1:0] OP_BEQ   = OPC_W'(6'b000100);
  localparam logic [OPC_W-1:0] OP_J     = OPC_W'(6'b000010);
  localparam logic [OPC_W-1:0] OP_ADDI  = OPC_W'(6'b001000);

  state_t r_state;
  state_t w_next;
  logic   w_illegal;

  always_comb begin
    w_next    = FETCH;
    w_illegal = 1'b0;
    case (r_state)
      FETCH:  w_next = mem_ready ? DECODE : FETCH;
      DECODE: begin
        case (opcode)
          OP_LW, OP_SW: w_next = MEMADR;
          OP_RTYPE:     w_next = EXEC;
          OP_BEQ:       w_next = BRANCH;
          OP_J:         w_next = JUMP;
          OP_ADDI:      w_next = ADDIEX;
          default: begin
            w_next    = FETCH;
            w_illegal = 1'b1;
          end
        endcase
      end
      MEMADR: w_next = (opcode == OP_LW) ? MEMRD : MEMWR;
      MEMRD:  w_next = mem_ready ? MEMWB : MEMRD;
      MEMWR:  w_next = mem_ready ? FETCH : MEMWR;
      EXEC:   w_next = ALUWB;
      ADDIEX: w_next = ADDIWB;
      default: w_next = FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) r_state <= FETCH;
    else        r_state <= w_next;
  end

  // Outputs follow the state combinationally so the PC/IR loads can be qualified
  // by mem_ready and zero in the same cycle the handshake completes.
  always_comb begin
    pc_en      = 1'b0;
    iord       = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    alu_op     = 2'b00;
    pc_source  = 2'b00;
    illegal_op = 1'b0;
    case (r_state)
      FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = mem_ready;
        pc_en     = mem_ready;
      end
      DECODE: begin
        alu_src_b  = 2'b11;
        illegal_op = w_illegal;
      end
      MEMADR, ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      MEMRD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
      end
      MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      MEMWR: begin
        mem_write = 1'b1;
        iord      = 1'b1;
      end
      EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
      end
      ALUWB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
      end
      BRANCH: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b01;
        pc_source = 2'b01;
        pc_en     = zero;
      end
      JUMP: begin
        pc_source = 2'b10;
        pc_en     = 1'b1;
      end
      ADDIWB: reg_write = 1'b1;
      default: ;
    endcase
    // Holding reset abandons any in-flight access immediately.
    if (!reset) begin
      pc_en      = 1'b0;
      iord       = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      ir_write   = 1'b0;
      reg_dst    = 1'b0;
      mem_to_reg = 1'b0;
      reg_write  = 1'b0;
      alu_src_a  = 1'b0;
      alu_src_b  = 2'b00;
      alu_op     = 2'b00;
      pc_source  = 2'b00;
      illegal_op = 1'b0;
    end
  end

  assign state = r_state;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed bench for mips_multicycle_ctrl: walks every instruction class cycle by
// cycle and compares the full control word against hand-derived values.
module tb_mips_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] opcode;
  logic       zero;
  logic       mem_ready;
  logic       pc_en, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg;
  logic       reg_write, alu_src_a, illegal_op;
  logic [1:0] alu_src_b, alu_op, pc_source;
  logic [3:0] state;

  int n_assert = 0;
  int n_fail   = 0;

  mips_multicycle_ctrl #(.STATE_W(4), .OPC_W(6)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .pc_en(pc_en), .iord(iord), .mem_read(mem_read), .mem_write(mem_write),
    .ir_write(ir_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_op(alu_op), .pc_source(pc_source), .illegal_op(illegal_op), .state(state)
  );

  always #5 clk = ~clk;

  logic [19:0] obs;
  assign obs = {state, pc_en, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg,
                reg_write, alu_src_a, alu_src_b, alu_op, pc_source, illegal_op};

  function automatic logic [19:0] ctl(input logic [3:0] st, input logic pce, iod, mrd,
                                      mwr, irw, rdst, m2r, rw, asa,
                                      input logic [1:0] asb, aop, psrc, input logic ill);
    return {st, pce, iod, mrd, mwr, irw, rdst, m2r, rw, asa, asb, aop, psrc, ill};
  endfunction

  // Apply inputs after the falling edge, let the decode settle, then compare.
  task automatic cyc(input string tag, input logic rst, input logic rdy,
                     input logic [5:0] op, input logic z, input logic [19:0] exp);
    @(negedge clk);
    reset = rst; mem_ready = rdy; opcode = op; zero = z;
    #1;
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%05h expected=%05h", tag, obs, exp);
    end
  endtask

  logic [19:0] E_FET, E_STALL, E_DEC, E_ILL, E_MADR, E_MRD, E_MWB, E_MWR;
  logic [19:0] E_EXEC, E_AWB, E_BR1, E_BR0, E_JMP, E_AEX, E_AWB2;

  initial begin
    reset = 1'b0; mem_ready = 1'b1; opcode = 6'b0; zero = 1'b0;
    E_FET   = ctl(4'd0, 1,0,1,0,1,0,0,0,0, 2'b01, 2'b00, 2'b00, 0);
    E_STALL = ctl(4'd0, 0,0,1,0,0,0,0,0,0, 2'b01, 2'b00, 2'b00, 0);
    E_DEC   = ctl(4'd1, 0,0,0,0,0,0,0,0,0, 2'b11, 2'b00, 2'b00, 0);
    E_ILL   = ctl(4'd1, 0,0,0,0,0,0,0,0,0, 2'b11, 2'b00, 2'b00, 1);
    E_MADR  = ctl(4'd2, 0,0,0,0,0,0,0,0,1, 2'b10, 2'b00, 2'b00, 0);
    E_MRD   = ctl(4'd3, 0,1,1,0,0,0,0,0,0, 2'b00, 2'b00, 2'b00, 0);
    E_MWB   = ctl(4'd4, 0,0,0,0,0,0,1,1,0, 2'b00, 2'b00, 2'b00, 0);
    E_MWR   = ctl(4'd5, 0,1,0,1,0,0,0,0,0, 2'b00, 2'b00, 2'b00, 0);
    E_EXEC  = ctl(4'd6, 0,0,0,0,0,0,0,0,1, 2'b00, 2'b10, 2'b00, 0);
    E_AWB   = ctl(4'd7, 0,0,0,0,0,1,0,1,0, 2'b00, 2'b00, 2'b00, 0);
    E_BR1   = ctl(4'd8, 1,0,0,0,0,0,0,0,1, 2'b00, 2'b01, 2'b01, 0);
    E_BR0   = ctl(4'd8, 0,0,0,0,0,0,0,0,1, 2'b00, 2'b01, 2'b01, 0);
    E_JMP   = ctl(4'd9, 1,0,0,0,0,0,0,0,0, 2'b00, 2'b00, 2'b10, 0);
    E_AEX   = ctl(4'd10,0,0,0,0,0,0,0,0,1, 2'b10, 2'b00, 2'b00, 0);
    E_AWB2  = ctl(4'd11,0,0,0,0,0,0,0,1,0, 2'b00, 2'b00, 2'b00, 0);

    // Reset held for three clocks, then released into FETCH.
    for (int i = 0; i < 3; i++) cyc("reset_hold", 0, 1, 6'b100011, 0, 20'h0);
    cyc("first_fetch", 1, 1, 6'b100011, 0, E_FET);

    // lw, zero wait states: 0,1,2,3,4,0
    cyc("lw_decode", 1, 1, 6'b100011, 0, E_DEC);
    cyc("lw_memadr", 1, 1, 6'b100011, 0, E_MADR);
    cyc("lw_memrd",  1, 1, 6'b100011, 0, E_MRD);
    cyc("lw_memwb",  1, 1, 6'b100011, 0, E_MWB);

    // sw with three wait cycles in MEMWR
    cyc("sw_fetch",  1, 1, 6'b101011, 0, E_FET);
    cyc("sw_decode", 1, 1, 6'b101011, 0, E_DEC);
    cyc("sw_memadr", 1, 1, 6'b101011, 0, E_MADR);
    for (int i = 0; i < 3; i++) cyc("sw_wait", 1, 0, 6'b101011, 0, E_MWR);
    cyc("sw_ready",  1, 1, 6'b101011, 0, E_MWR);

    // beq taken then not taken
    cyc("beq1_fetch",  1, 1, 6'b000100, 1, E_FET);
    cyc("beq1_decode", 1, 1, 6'b000100, 1, E_DEC);
    cyc("beq1_branch", 1, 1, 6'b000100, 1, E_BR1);
    cyc("beq0_fetch",  1, 1, 6'b000100, 0, E_FET);
    cyc("beq0_decode", 1, 1, 6'b000100, 0, E_DEC);
    cyc("beq0_branch", 1, 1, 6'b000100, 0, E_BR0);

    // R-type, with one FETCH stall first
    cyc("r_fetch_stall", 1, 0, 6'b000000, 0, E_STALL);
    cyc("r_fetch",  1, 1, 6'b000000, 0, E_FET);
    cyc("r_decode", 1, 1, 6'b000000, 0, E_DEC);
    cyc("r_exec",   1, 1, 6'b000000, 0, E_EXEC);
    cyc("r_aluwb",  1, 1, 6'b000000, 0, E_AWB);

    // addi
    cyc("addi_fetch",  1, 1, 6'b001000, 0, E_FET);
    cyc("addi_decode", 1, 1, 6'b001000, 0, E_DEC);
    cyc("addi_exec",   1, 1, 6'b001000, 0, E_AEX);
    cyc("addi_wb",     1, 1, 6'b001000, 0, E_AWB2);

    // j
    cyc("j_fetch",  1, 1, 6'b000010, 0, E_FET);
    cyc("j_decode", 1, 1, 6'b000010, 0, E_DEC);
    cyc("j_jump",   1, 1, 6'b000010, 0, E_JMP);

    // illegal opcode: single-cycle pulse, straight back to FETCH
    cyc("ill_fetch",  1, 1, 6'b111111, 0, E_FET);
    cyc("ill_decode", 1, 1, 6'b111111, 0, E_ILL);
    cyc("ill_after",  1, 1, 6'b111111, 0, E_FET);

    // reset during a MEMRD wait abandons the load
    cyc("rst_decode", 1, 1, 6'b100011, 0, E_DEC);
    cyc("rst_memadr", 1, 1, 6'b100011, 0, E_MADR);
    cyc("rst_memrd_wait", 1, 0, 6'b100011, 0, E_MRD);
    cyc("rst_in_memrd", 0, 0, 6'b100011, 0, ctl(4'd3, 0,0,0,0,0,0,0,0,0, 2'b00, 2'b00, 2'b00, 0));
    cyc("rst_to_fetch", 1, 1, 6'b100011, 0, E_FET);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
